fifo_uart_tx: RTL and testbench

Downstream consumer of fifo_interface. It drains bytes from the SRAM-backed FIFO with active-low fiford read strobes and serializes each byte onto a UART TX line: 1 start bit, 8 data bits LSB first, optional even parity, 1 stop bit. It sits between fifo_interface (out_data, nempty, fiford) and the board serial pin.

---
 rtl/fifo_uart_tx_if.sv | 9 +
 rtl/fifo_uart_tx.sv | 150 +++++++++++++++
 tb/tb_fifo_uart_tx.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/fifo_uart_tx_if.sv
// Read-side handshake between fifo_interface (master) and fifo_uart_tx (slave).
interface fifo_uart_tx_if;
  logic       nempty;
  logic [7:0] fifo_data;
  logic       fiford;

  modport master (output nempty, output fifo_data, input fiford);
  modport slave  (input nempty, input fifo_data, output fiford);
endinterface

// File: rtl/fifo_uart_tx.sv
// Drains bytes from the SRAM-backed FIFO with an active-low read strobe and
// serializes them as UART frames: start, 8 data LSB first, optional even parity, stop.
module fifo_uart_tx #(
  parameter int unsigned CLK_DIV   = 16,
  parameter int unsigned RD_PULSE  = 4,
  parameter int unsigned RD_GAP    = 1,
  parameter int unsigned PARITY_EN = 0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            enable,
  fifo_uart_tx_if.slave   fifo,
  output logic            tx,
  output logic            busy,
  output logic [15:0]     tx_count
);

  localparam int unsigned MAX_A = (CLK_DIV > RD_PULSE) ? CLK_DIV : RD_PULSE;
  localparam int unsigned MAX_P = (MAX_A > RD_GAP) ? MAX_A : RD_GAP;
  localparam int unsigned CW    = (MAX_P < 2) ? 1 : $clog2(MAX_P);

  localparam logic [CW-1:0] RD_LAST  = CW'(RD_PULSE - 1);
  localparam logic [CW-1:0] GAP_LAST = CW'(RD_GAP - 1);
  localparam logic [CW-1:0] BIT_LAST = CW'(CLK_DIV - 1);
  localparam bit            HAS_PAR  = (PARITY_EN != 0);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD,
    S_GAP,
    S_START,
    S_DATA,
    S_PAR,
    S_STOP
  } state_e;

  state_e        state_q;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;
  logic [2:0]    idx_q;
  logic [7:0]    data_q;
  logic          fiford_q;
  logic          tx_q;
  logic          busy_q;
  logic [15:0]   tx_count_q;

  always_comb begin
    cnt_d = cnt_q + CW'(1);
  end

  // One shared counter times the read pulse, the gap and every bit period;
  // it restarts at zero on each state change.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      idx_q      <= '0;
      data_q     <= '0;
      fiford_q   <= 1'b1;
      tx_q       <= 1'b1;
      busy_q     <= 1'b0;
      tx_count_q <= '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (enable && fifo.nempty) begin
            fiford_q <= 1'b0;
            busy_q   <= 1'b1;
            cnt_q    <= '0;
            state_q  <= S_RD;
          end
        end
        S_RD: begin
          if (cnt_q == RD_LAST) begin
            fiford_q <= 1'b1;
            data_q   <= fifo.fifo_data;
            cnt_q    <= '0;
            state_q  <= S_GAP;
          end else begin
            cnt_q <= cnt_d;
          end
        end
        S_GAP: begin
          if (cnt_q == GAP_LAST) begin
            tx_q    <= 1'b0;
            cnt_q   <= '0;
            state_q <= S_START;
          end else begin
            cnt_q <= cnt_d;
          end
        end
        S_START: begin
          if (cnt_q == BIT_LAST) begin
            cnt_q   <= '0;
            idx_q   <= '0;
            tx_q    <= data_q[0];
            state_q <= S_DATA;
          end else begin
            cnt_q <= cnt_d;
          end
        end
        S_DATA: begin
          if (cnt_q == BIT_LAST) begin
            cnt_q <= '0;
            if (idx_q == 3'd7) begin
              if (HAS_PAR) begin
                tx_q    <= ^data_q;
                state_q <= S_PAR;
              end else begin
                tx_q    <= 1'b1;
                state_q <= S_STOP;
              end
            end else begin
              idx_q <= idx_q + 3'd1;
              tx_q  <= data_q[idx_q + 3'd1];
            end
          end else begin
            cnt_q <= cnt_d;
          end
        end
        S_PAR: begin
          if (cnt_q == BIT_LAST) begin
            cnt_q   <= '0;
            tx_q    <= 1'b1;
            state_q <= S_STOP;
          end else begin
            cnt_q <= cnt_d;
          end
        end
        S_STOP: begin
          if (cnt_q == BIT_LAST) begin
            cnt_q      <= '0;
            busy_q     <= 1'b0;
            tx_count_q <= tx_count_q + 16'd1;
            state_q    <= S_IDLE;
          end else begin
            cnt_q <= cnt_d;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign fifo.fiford = fiford_q;
  assign tx          = tx_q;
  assign busy        = busy_q;
  assign tx_count    = tx_count_q;

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Scoreboard bench for fifo_uart_tx: channel 0 without parity, channel 1 with parity.
module tb_fifo_uart_tx;

  localparam int CDIV = 4;
  localparam int RDP  = 4;
  localparam int RDG  = 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   n_chk = 0;
  int   n_pass = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  function automatic logic [10:0] frame10(input logic [7:0] d);
    return {2'b01, d, 1'b0};
  endfunction

  for (genvar g = 0; g < 2; g++) begin : ch
    localparam int NB = 10 + g;

    fifo_uart_tx_if fif ();
    logic        en;
    logic        tx;
    logic        busy;
    logic [15:0] cnt;
    logic [7:0]  fq [$];
    logic [10:0] sb [$];
    int          pulses = 0;
    int          last_fall = 0;
    logic [15:0] exp_cnt = '0;
    bit          chk_b2b = 1'b0;
    logic        prev_rd;
    logic [10:0] fr;
    bit          wid_ok;
    bit          abort_f;

    fifo_uart_tx #(
      .CLK_DIV  (CDIV),
      .RD_PULSE (RDP),
      .RD_GAP   (RDG),
      .PARITY_EN(g)
    ) u_dut (
      .clk     (clk),
      .rst     (rst_n),
      .enable  (en),
      .fifo    (fif.slave),
      .tx      (tx),
      .busy    (busy),
      .tx_count(cnt)
    );

    // FIFO model: data valid for the whole strobe, popped once it is released.
    initial begin
      prev_rd = 1'b1;
      fif.nempty = 1'b0;
      fif.fifo_data = '0;
      forever begin
        @(negedge clk);
        if (prev_rd === 1'b1 && fif.fiford === 1'b0) begin
          pulses++;
          last_fall = cyc;
        end
        if (prev_rd === 1'b0 && fif.fiford === 1'b1) begin
          check($sformatf("ch%0d_rd_width", g), cyc - last_fall, RDP);
          if (fq.size() != 0) void'(fq.pop_front());
        end
        prev_rd = fif.fiford;
        fif.nempty = (fq.size() != 0);
        fif.fifo_data = (fq.size() != 0) ? fq[0] : 8'h00;
      end
    end

    // Frame monitor: samples every cycle of a frame, compares against the scoreboard.
    initial forever begin
      @(negedge clk);
      if (rst_n === 1'b1 && tx === 1'b0) begin
        check($sformatf("ch%0d_tx_latency", g), cyc - last_fall, RDP + RDG);
        fr = '0;
        wid_ok = 1'b1;
        abort_f = 1'b0;
        for (int b = 0; b < NB; b++) begin
          for (int s = 0; s < CDIV; s++) begin
            if (b != 0 || s != 0) @(negedge clk);
            if (rst_n !== 1'b1) abort_f = 1'b1;
            else if (s == 0) fr[b] = tx;
            else if (tx !== fr[b]) wid_ok = 1'b0;
            if (abort_f) break;
          end
          if (abort_f) break;
        end
        if (!abort_f) begin
          @(negedge clk);
          exp_cnt = exp_cnt + 16'd1;
          check($sformatf("ch%0d_bit_width", g), wid_ok, 1);
          check($sformatf("ch%0d_sb_nonempty", g), sb.size() != 0, 1);
          if (sb.size() != 0) check($sformatf("ch%0d_frame", g), fr, sb.pop_front());
          check($sformatf("ch%0d_post_frame", g), {busy, tx, cnt}, {1'b0, 1'b1, exp_cnt});
          if (chk_b2b && sb.size() != 0) begin
            @(negedge clk);
            check($sformatf("ch%0d_b2b_gap", g), {busy, fif.fiford}, 2'b10);
          end
        end
      end
    end
  end

  task automatic push0(input logic [7:0] d);
    ch[0].fq.push_back(d);
    ch[0].sb.push_back(frame10(d));
  endtask

  task automatic wait_drain(input int c, input int limit);
    int n = 0;
    while (((c == 0) ? (ch[0].sb.size() != 0 || ch[0].busy !== 1'b0)
                     : (ch[1].sb.size() != 0 || ch[1].busy !== 1'b0)) && n < limit) begin
      @(negedge clk);
      n++;
    end
    check($sformatf("ch%0d_drain_in_time", c), n < limit, 1);
  endtask

  task automatic wait_start0(input int limit);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (ch[0].tx !== 1'b0 && n < limit);
    check("ch0_start_seen", ch[0].tx, 0);
  endtask

  logic [7:0] burst [8] = '{8'h3C, 8'h00, 8'hFF, 8'h81, 8'h5A, 8'h12, 8'hE7, 8'h6D};

  initial begin
    ch[0].en = 1'b0;
    ch[1].en = 1'b0;

    // Reset state, then idle with an empty FIFO.
    @(negedge clk);
    check("reset_ch0", {ch[0].fif.fiford, ch[0].tx, ch[0].busy, ch[0].cnt}, {3'b110, 16'h0000});
    check("reset_ch1", {ch[1].fif.fiford, ch[1].tx, ch[1].busy, ch[1].cnt}, {3'b110, 16'h0000});
    @(posedge clk);
    #1 rst_n = 1'b1;
    ch[0].en = 1'b1;
    ch[1].en = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      check("idle_empty", {ch[0].fif.fiford, ch[0].tx, ch[0].busy, ch[0].cnt}, {3'b110, 16'h0000});
    end
    check("idle_no_pulse", ch[0].pulses, 0);

    // Single byte 0xA5: frame 0,1,0,1,0,0,1,0,1,1 LSB first.
    @(posedge clk);
    #1 push0(8'hA5);
    wait_drain(0, 200);
    check("single_pulses", ch[0].pulses, 1);
    check("single_count", ch[0].cnt, 16'd1);

    // Burst drain with back-to-back frames.
    @(posedge clk);
    #1 ch[0].chk_b2b = 1'b1;
    for (int i = 0; i < 8; i++) push0(burst[i]);
    wait_drain(0, 1000);
    ch[0].chk_b2b = 1'b0;
    repeat (50) @(negedge clk);
    check("burst_pulses", ch[0].pulses, 9);
    check("burst_count", ch[0].cnt, 16'd9);
    check("burst_fiford_idle", ch[0].fif.fiford, 1);

    // Reset during data bit 3; the next byte must go out intact.
    @(posedge clk);
    #1 push0(8'h96);
    push0(8'h4B);
    wait_start0(100);
    repeat (17) @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("midreset_outputs", {ch[0].fif.fiford, ch[0].tx, ch[0].busy, ch[0].cnt}, {3'b110, 16'h0000});
    void'(ch[0].sb.pop_front());
    ch[0].exp_cnt = '0;
    ch[1].exp_cnt = '0;
    wait_drain(0, 300);
    check("midreset_pulses", ch[0].pulses, 11);
    check("midreset_count", ch[0].cnt, 16'd1);

    // Enable dropped during STOP with data still queued.
    @(posedge clk);
    #1 push0(8'h3C);
    push0(8'hC3);
    wait_start0(100);
    repeat (37) @(posedge clk);
    #1 ch[0].en = 1'b0;
    repeat (60) @(negedge clk);
    check("gated_pulses", ch[0].pulses, 12);
    check("gated_busy", {ch[0].busy, ch[0].fif.fiford}, 2'b01);
    check("gated_count", ch[0].cnt, 16'd2);

    // Counter wrap on the held byte.
    @(posedge clk);
    #1 force ch[0].u_dut.tx_count_q = 16'hFFFF;
    @(posedge clk);
    #1 release ch[0].u_dut.tx_count_q;
    ch[0].exp_cnt = 16'hFFFF;
    ch[0].en = 1'b1;
    wait_drain(0, 300);
    check("wrap_count", ch[0].cnt, 16'h0000);
    check("wrap_pulses", ch[0].pulses, 13);

    // Parity channel: 0x07 -> parity 1, 0x03 -> parity 0, 11-bit frames.
    @(posedge clk);
    #1 ch[1].chk_b2b = 1'b1;
    ch[1].fq.push_back(8'h07);
    ch[1].sb.push_back(11'h60E);
    ch[1].fq.push_back(8'h03);
    ch[1].sb.push_back(11'h406);
    wait_drain(1, 400);
    check("par_pulses", ch[1].pulses, 2);
    check("par_count", ch[1].cnt, 16'd2);

    repeat (5) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
